// File: rtl/uart_tx_fifo1.sv
// uart_tx_fifo1: 8N1 UART transmitter with a one-byte holding register in front
// of the shifter, so the next byte can be accepted while a frame is going out.
//
// state | meaning
// IDLE  | line idle high, waiting for the holding register to fill
// START | start bit (low) for CPB cycles
// DATA  | eight data bits, LSB first, CPB cycles each
// STOP  | stop bit (high) for CPB cycles; may chain straight into START
module uart_tx_fifo1 #(
    parameter int CLK_MHZ = 12,
    parameter int BAUD    = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy
);

    localparam int CPB   = (CLK_MHZ * 1000000 + BAUD / 2) / BAUD;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CPB - 1);

    // Divisors below 4 leave too few cycles per bit for the registered line output.
    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_tx_fifo1: cycles per bit %0d is below the minimum of 4", CPB);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic             tx_q, tx_nxt;
    logic             line_busy;
    logic             load;
    logic             accept;

    // State and datapath registers; reset aborts any frame and drops the held byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_q      <= 1'b1;
            line_busy <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shift     <= shift_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            tx_q      <= tx_nxt;
            // The line lags the state by one flop, so busy is stretched to cover
            // the last stop-bit cycle still on the wire.
            line_busy <= (state != IDLE);
        end
    end

    // Next-state, bit timing, holding register handoff and line level.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        shift_nxt     = shift;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        tx_nxt        = 1'b1;
        load          = 1'b0;
        accept        = tx_valid & ~hold_full;

        case (state)
            IDLE: begin
                if (hold_full) load = 1'b1;
            end
            START: begin
                tx_nxt = 1'b0;
                if (cnt == '0) begin
                    state_nxt = DATA;
                    cnt_nxt   = CNT_TOP;
                    idx_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DATA: begin
                tx_nxt = shift[0];
                if (cnt == '0) begin
                    cnt_nxt   = CNT_TOP;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (idx == 3'd7) state_nxt = STOP;
                    else             idx_nxt   = idx + 3'd1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (hold_full) load = 1'b1;
                    else           state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Load needs a full register and accept needs an empty one, so they never collide.
        if (load) begin
            shift_nxt     = hold;
            hold_full_nxt = 1'b0;
            state_nxt     = START;
            cnt_nxt       = CNT_TOP;
        end
        if (accept) begin
            hold_nxt      = tx_data;
            hold_full_nxt = 1'b1;
        end
    end

    assign tx_ready = ~hold_full;
    assign uart_tx  = tx_q;
    assign busy     = line_busy | hold_full | (state != IDLE);

endmodule

// File: doc/uart_tx_fifo1.md
UART_TX_FIFO1 -- requirements
Module: uart_tx_fifo1

Interface
REQ-001 Parameter CLK_MHZ, default 12, system clock frequency in MHz.
REQ-002 Parameter BAUD, default 115200, line rate in bits/s.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tx_data  input  8  byte to transmit, sampled on accept.
REQ-006 tx_valid  input  1  producer offers tx_data.
REQ-007 tx_ready  output  1  holding register empty; a byte can be accepted.
REQ-008 uart_tx  output  1  serial line, idle high; drives the board pin directly.
REQ-009 busy  output  1  a frame is on the line or a byte is held.

Function
REQ-010 The block SHALL use the divisor CPB = (CLK_MHZ*1000000 + BAUD/2) / BAUD, computed at elaboration; the default is 104.
REQ-011 Elaboration SHALL fail if CPB < 4.
REQ-012 Accept rule: a byte SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; no other cycle accepts.
REQ-013 A one-byte holding register SHALL store an accepted byte; tx_ready SHALL be registered and equal the holding register's empty state.
REQ-014 tx_data and tx_valid SHALL be ignored while tx_ready=0; the producer holds them, but the block does not require it.
REQ-015 The shifter FSM SHALL have states IDLE, START, DATA, STOP; it uses a bit-time counter 0..CPB-1 and a bit index 0..7.
REQ-016 IDLE: uart_tx=1; when the holding register is full, the FSM SHALL move the byte into the shifter, empty the holding register, and enter START on the next edge.
REQ-017 START: uart_tx=0 for exactly CPB cycles, then DATA with index 0.
REQ-018 DATA: uart_tx SHALL carry the shifter bit, LSB first; each bit lasts exactly CPB cycles; after bit 7 the FSM enters STOP.
REQ-019 STOP: uart_tx=1 for exactly CPB cycles.
REQ-020 At the end of STOP, if the holding register is full, the FSM SHALL go directly to START with the held byte, giving zero idle cycles between frames; otherwise it goes to IDLE.
REQ-021 The holding register SHALL be freed in the cycle its byte is loaded into the shifter, so a new accept can occur while the previous frame is still transmitting.
REQ-022 Simultaneous accept and load in one cycle SHALL NOT occur, because an accept requires an empty register and a load requires a full one.
REQ-023 Latency: an accept at edge N with the FSM in IDLE SHALL make the load occur at N+1 and uart_tx fall at N+2.
REQ-024 uart_tx SHALL be driven from a flop, with no combinational path from any input.
REQ-025 busy SHALL be 1 whenever the FSM is not in IDLE or the holding register is full.
REQ-026 Frame length SHALL be exactly 10*CPB cycles: 1 start bit, 8 data bits, 1 stop bit, no parity.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set: FSM=IDLE, counters=0, holding register empty, uart_tx=1, tx_ready=1, busy=0.
REQ-028 Reset mid-frame SHALL abort the frame and discard any held byte; uart_tx SHALL return to 1 on the edge where rst is sampled.
REQ-029 tx_valid asserted during rst SHALL NOT be accepted.
REQ-030 After rst deasserts, the first accept is possible on the next edge.

Verification
REQ-031 Single byte at defaults: accept 0x55 -> uart_tx low at N+2; line reads 0,1,0,1,0,1,0,1,0,1 with each level 104 cycles; idle high afterwards; busy falls after 1040 line cycles.
REQ-032 Back-to-back: accept 0xA5, then 0x3C as soon as tx_ready rises -> two contiguous frames totalling 2080 cycles; second start bit begins the cycle after the first stop bit ends; tx_ready drops on each accept.
REQ-033 Backpressure: hold tx_valid=1 with 0x11, 0x22, 0x33 sequenced on accept -> exactly three frames in order, no byte duplicated or lost; tx_ready=0 whenever the register is full.
REQ-034 Reset mid-frame: assert rst for 1 cycle during DATA bit 3 of 0xF0 with 0x0F held -> uart_tx=1 the next cycle; no further frames; tx_ready=1, busy=0.
REQ-035 Parameter sweep: CLK_MHZ=12, BAUD=3000000 (CPB=4) -> each bit is exactly 4 cycles; BAUD giving CPB<4 -> elaboration error.
